// File: rtl/instr_buffer_sequencer_pkg.sv
// Shared definitions for the instruction buffer sequencer: FSM state type,
// default bubble word and the index-width helper used by every file.
package instr_buffer_sequencer_pkg;

    localparam int          INSTR_WORD_SIZE_DEF = 32;
    localparam int          BS_DEF              = 16;
    localparam logic [31:0] NOP_WORD_DEF        = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } seq_state_t;

    // Width of an index into a buffer of 'depth' entries (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_buffer_sequencer_if.sv
// Handshake and buffer-side signals of the sequencer. The master side is the
// upstream producer / downstream observer; the slave side is the sequencer.
interface instr_buffer_sequencer_if
    import instr_buffer_sequencer_pkg::*;
#(
    parameter int Instr_word_size = INSTR_WORD_SIZE_DEF,
    parameter int bs              = BS_DEF
);
    localparam int IW = idx_width(bs);

    logic                       in_valid;
    logic [Instr_word_size-1:0] in_instr;
    logic                       in_ready;
    logic                       flush;
    logic [IW-1:0]              buffer_index;
    logic [Instr_word_size-1:0] Instr_in;
    logic                       out_valid;
    logic [IW:0]                occupancy;
    logic                       flush_done;
    logic [15:0]                bubble_count;

    modport master (
        output in_valid, in_instr, flush,
        input  in_ready, buffer_index, Instr_in, out_valid, occupancy,
               flush_done, bubble_count
    );

    modport slave (
        input  in_valid, in_instr, flush,
        output in_ready, buffer_index, Instr_in, out_valid, occupancy,
               flush_done, bubble_count
    );

endinterface

// File: rtl/instr_buffer_sequencer_vbit_popcount.sv
// Population count of the valid-bit mirror; yields the number of real entries.
module vbit_popcount
    import instr_buffer_sequencer_pkg::*;
#(
    parameter int WIDTH = BS_DEF
) (
    input  logic [WIDTH-1:0]            bits,
    output logic [idx_width(WIDTH):0]   count
);
    localparam int CW = idx_width(WIDTH);

    // Sum the mirror bits one at a time.
    always_comb begin
        count = {(CW + 1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            count = count + {{CW{1'b0}}, bits[i]};
        end
    end

endmodule

// File: rtl/instr_buffer_sequencer.sv
// Upstream feeder for the instruction buffer. Advances a circular write index
// every cycle, writes accepted instructions or NOP bubbles, mirrors which
// buffer slots hold real instructions and runs a flush/drain sequence.
// Optional feature: define INSTR_SEQ_BUBBLE_CNT_EN to enable the saturating
// bubble counter; otherwise bubble_count is tied to zero.
module instr_buffer_sequencer
    import instr_buffer_sequencer_pkg::*;
#(
    parameter int                         Instr_word_size = INSTR_WORD_SIZE_DEF,
    parameter int                         bs              = BS_DEF,
    parameter logic [Instr_word_size-1:0] NOP_WORD        = Instr_word_size'(NOP_WORD_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_buffer_sequencer_if.slave   bus
);
    localparam int            IW      = idx_width(bs);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    logic [IW-1:0]              idx_r;
    logic [bs-1:0]              vbit_r;
    seq_state_t                 state_r;
    logic                       out_valid_r;
    logic [IW:0]                occ_s;
    logic                       in_ready_s;
    logic                       accept_s;
    logic                       flush_done_s;
    logic [Instr_word_size-1:0] instr_in_s;

    vbit_popcount #(.WIDTH(bs)) u_popcount (
        .bits  (vbit_r),
        .count (occ_s)
    );

    // Handshake decode and the drain-complete indication from registered state.
    always_comb begin
        in_ready_s   = (state_r == ST_RUN);
        accept_s     = bus.in_valid && in_ready_s;
        flush_done_s = (state_r == ST_DRAIN) && (occ_s == {(IW + 1){1'b0}});
    end

    // Select the word the buffer writes this cycle: real instruction or bubble.
    always_comb begin
        instr_in_s = NOP_WORD;
        if (accept_s) begin
            instr_in_s = bus.in_instr;
        end else begin
            instr_in_s = NOP_WORD;
        end
    end

    // Index walk plus valid mirror; out_valid captures the slot before overwrite,
    // matching the buffer's read-before-write behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r       <= {IW{1'b0}};
            vbit_r      <= {bs{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r   <= vbit_r[idx_r];
            vbit_r[idx_r] <= accept_s;
            idx_r         <= idx_r + IDX_ONE;
        end
    end

    // Run/drain control: flush enters drain, drain exits once the mirror is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.flush) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (flush_done_s) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

`ifdef INSTR_SEQ_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_r;

    // Count cycles that write a bubble, saturating at the top value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_r <= 16'h0000;
        end else if (!accept_s && (bubble_cnt_r != 16'hFFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'h0001;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bus.bubble_count = bubble_cnt_r;
`else
    assign bus.bubble_count = 16'h0000;
`endif

    assign bus.in_ready     = in_ready_s;
    assign bus.buffer_index = idx_r;
    assign bus.Instr_in     = instr_in_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.occupancy    = occ_s;
    assign bus.flush_done   = flush_done_s;

endmodule

// File: tb/tb_instr_buffer_sequencer.sv
// Bench for instr_buffer_sequencer: directed stimulus, a history-based model
// of which buffer slots hold real words, and a model of the downstream buffer.
module tb_instr_buffer_sequencer;

    localparam int          BS  = 16;
    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          HMAX = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instr_buffer_sequencer_if #(.Instr_word_size(W), .bs(BS)) bus ();

    instr_buffer_sequencer #(.Instr_word_size(W), .bs(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Downstream buffer: read-before-write memory written on every edge.
    logic [W-1:0] mem [BS];
    logic [W-1:0] instr_out;
    always @(posedge clk) begin
        instr_out <= mem[bus.buffer_index];
        mem[bus.buffer_index] <= bus.Instr_in;
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: hist[e]/hdata[e] record what edge e (1-based since reset) wrote.
    int         n = 0;
    bit         hist [HMAX];
    logic [W-1:0] hdata [HMAX];
    bit         drn = 1'b0;
    int         bub = 0;
    int         done_seen = 0;
    int         exp_occ;
    bit         exp_ready, exp_done, exp_ov, acc;

    function automatic int occ_model(input int cur);
        int s = 0;
        for (int e = cur - BS + 1; e <= cur; e++) begin
            if (e >= 1) s += int'(hist[e]);
        end
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            n   = 0;
            drn = 1'b0;
            bub = 0;
            check("rst_index", 64'(bus.buffer_index), 64'd0);
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_occupancy", 64'(bus.occupancy), 64'd0);
            check("rst_flush_done", 64'(bus.flush_done), 64'd0);
            check("rst_bubble", 64'(bus.bubble_count), 64'd0);
        end else if (n < HMAX - 2) begin
            exp_occ   = occ_model(n);
            exp_ready = !drn;
            exp_done  = drn && (exp_occ == 0);
            exp_ov    = (n > BS) ? hist[n - BS] : 1'b0;
            acc       = bus.in_valid && exp_ready;
            check("index", 64'(bus.buffer_index), 64'(n % BS));
            check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            check("occupancy", 64'(bus.occupancy), 64'(exp_occ));
            check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            check("flush_done", 64'(bus.flush_done), 64'(exp_done));
            check("instr_in", 64'(bus.Instr_in), 64'(acc ? bus.in_instr : NOP));
            if (exp_ov) check("instr_out", 64'(instr_out), 64'(hdata[n - BS]));
`ifdef INSTR_SEQ_BUBBLE_CNT_EN
            check("bubble_count", 64'(bus.bubble_count), 64'(bub));
`else
            check("bubble_count", 64'(bus.bubble_count), 64'd0);
`endif
            if (bus.flush_done) done_seen++;
            // Advance to the state after the coming edge.
            n = n + 1;
            hist[n]  = acc;
            hdata[n] = bus.in_instr;
            if (!acc && bub < 65535) bub++;
            if (!drn) begin
                if (bus.flush) drn = 1'b1;
            end else if (exp_occ == 0) begin
                drn = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int k;
    int d0;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.flush    = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // Idle after reset: index walks 0..15,0..3 with bubbles only.
        for (int i = 0; i < 20; i++) begin
            check("idle_index", 64'(bus.buffer_index), 64'(i % BS));
            check("idle_instr_in", 64'(bus.Instr_in), 64'h13);
            tick();
        end
`ifdef INSTR_SEQ_BUBBLE_CNT_EN
        check("idle_bubbles", 64'(bus.bubble_count), 64'd20);
`endif

        // Single instruction at index 3, observed 16 edges later.
        repeat (15) tick();
        check("single_at_idx3", 64'(bus.buffer_index), 64'd3);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hAAAA_0001;
        tick();
        bus.in_valid = 1'b0;
        check("single_occ1", 64'(bus.occupancy), 64'd1);
        repeat (15) tick();
        check("single_not_yet", 64'(bus.out_valid), 64'd0);
        tick();
        check("single_out", 64'(instr_out), 64'hAAAA_0001);
        check("single_out_valid", 64'(bus.out_valid), 64'd1);
        check("single_occ0", 64'(bus.occupancy), 64'd0);

        // Back-to-back stream: occupancy saturates at the buffer depth.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.in_instr = 32'hB000_0000 + 32'(i);
            tick();
            if (i >= 15) check("stream_occ16", 64'(bus.occupancy), 64'd16);
        end
        bus.in_valid = 1'b0;
        repeat (BS) tick();
        check("stream_empty", 64'(bus.occupancy), 64'd0);

        // Flush with five real entries, the fifth offered with flush itself.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_instr = 32'hC000_0000 + 32'(i);
            tick();
        end
        bus.in_instr = 32'hC000_0004;
        bus.flush    = 1'b1;
        d0 = done_seen;
        tick();
        bus.flush    = 1'b0;
        bus.in_instr = 32'hDEAD_BEEF;
        check("flush_ready_low", 64'(bus.in_ready), 64'd0);
        check("flush_occ5", 64'(bus.occupancy), 64'd5);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.flush_done) begin
                k = i;
                break;
            end
        end
        check("flush_done_latency", 64'(k), 64'd16);
        bus.in_valid = 1'b0;
        tick();
        check("flush_done_once", 64'(done_seen - d0), 64'd1);
        check("flush_ready_back", 64'(bus.in_ready), 64'd1);
        check("flush_done_low", 64'(bus.flush_done), 64'd0);

        // Flush while empty: a single drain cycle carries the done pulse.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("empty_flush_ready", 64'(bus.in_ready), 64'd0);
        check("empty_flush_done", 64'(bus.flush_done), 64'd1);
        tick();
        check("empty_flush_run", 64'(bus.in_ready), 64'd1);
        check("empty_flush_done_low", 64'(bus.flush_done), 64'd0);

        // Reset in the middle of a drain aborts it without a done pulse.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_instr = 32'hE000_0000 + 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush    = 1'b0;
        repeat (2) tick();
        check("mid_drain_state", 64'(bus.in_ready), 64'd0);
        d0 = done_seen;
        rst = 1'b0;
        #1;
        check("abort_ready", 64'(bus.in_ready), 64'd1);
        check("abort_occ", 64'(bus.occupancy), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_index", 64'(bus.buffer_index), 64'd0);
        check("abort_bubble", 64'(bus.bubble_count), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (20) tick();
        check("abort_no_done", 64'(done_seen - d0), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
